vga_pixel_fetch: RTL

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Monochrome framebuffer pixel fetch for a VGA timing generator.
// Eight pixels per byte (MSB leftmost). A two-entry palette is double-buffered:
// writes land in a shadow bank and are committed to the active bank on the
// rising edge of vertical sync, so colours never change mid-frame.
module vga_pixel_fetch #(
  parameter logic [23:0] PAL0_RESET = 24'h000000,
  parameter logic [23:0] PAL1_RESET = 24'hFFFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [18:0] mem_add,
  input  logic        vga_blank,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic [15:0] fb_rd_addr,
  input  logic [7:0]  fb_rd_data,
  input  logic        pal_we,
  input  logic        pal_sel,
  input  logic [23:0] pal_data,
  output logic        pal_pending,
  output logic [15:0] frame_count,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  // Stage-1 registers (aligned with fb_rd_data)
  logic [2:0]  pix_s1_q;
  logic        blank_s1_q;
  logic        hsync_s1_q;
  logic        vsync_s1_q;

  // Palette banks
  logic [23:0] shadow0_q, shadow1_q;
  logic [23:0] active0_q, active1_q;
  logic        pending_q;
  logic [15:0] frame_count_q;

  // Stage-2 registers (outputs)
  logic [23:0] colour_q;
  logic        hsync_s2_q;
  logic        vsync_s2_q;
  logic        blank_s2_q;

  logic        commit;
  logic        pix_bit;
  logic [23:0] colour_d;

  assign fb_rd_addr = mem_add[18:3];

  // Rising vsync: the input is high while its one-cycle-old copy is low
  assign commit = vga_vsync & ~vsync_s1_q;

  // Pick the pixel bit and map it through the active palette
  always_comb begin
    colour_d = 24'h000000;
    pix_bit  = fb_rd_data[3'd7 - pix_s1_q];
    if (blank_s1_q) begin
      colour_d = pix_bit ? active1_q : active0_q;
    end
  end

  // Stage 1: pixel index within the byte and timing, one cycle behind the inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_s1_q   <= 3'd0;
      blank_s1_q <= 1'b0;
      hsync_s1_q <= 1'b1;
      vsync_s1_q <= 1'b0;
    end else begin
      pix_s1_q   <= mem_add[2:0];
      blank_s1_q <= vga_blank;
      hsync_s1_q <= vga_hsync;
      vsync_s1_q <= vga_vsync;
    end
  end

  // Palette banks: shadow takes writes, active takes the pre-write shadow on commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow0_q <= PAL0_RESET;
      shadow1_q <= PAL1_RESET;
      active0_q <= PAL0_RESET;
      active1_q <= PAL1_RESET;
    end else begin
      if (pal_we) begin
        if (pal_sel) begin
          shadow1_q <= pal_data;
        end else begin
          shadow0_q <= pal_data;
        end
      end
      if (commit) begin
        active0_q <= shadow0_q;
        active1_q <= shadow1_q;
      end
    end
  end

  // Pending flag and frame counter; a write in the commit cycle keeps pending set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      if (pal_we) begin
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
      if (commit) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  // Stage 2: colour and timing registered together so they stay aligned
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      colour_q   <= 24'h000000;
      hsync_s2_q <= 1'b1;
      vsync_s2_q <= 1'b0;
      blank_s2_q <= 1'b0;
    end else begin
      colour_q   <= colour_d;
      hsync_s2_q <= hsync_s1_q;
      vsync_s2_q <= vsync_s1_q;
      blank_s2_q <= blank_s1_q;
    end
  end

  assign vga_r       = colour_q[23:16];
  assign vga_g       = colour_q[15:8];
  assign vga_b       = colour_q[7:0];
  assign hsync_out   = hsync_s2_q;
  assign vsync_out   = vsync_s2_q;
  assign blank_out   = blank_s2_q;
  assign pal_pending = pending_q;
  assign frame_count = frame_count_q;

endmodule
